// File: rtl/round_robin_arbiter_32.sv
// 32-requester round-robin arbiter built from four 8-way group arbiters
// feeding a 4-way group arbiter; grant is registered and one-hot or zero.
module round_robin_arbiter_32 #(
  parameter int REQ_NB = 32,
  parameter int GRP_NB = 4,
  parameter int GRP_SZ = 8
) (
  input  logic              clk_i,
  input  logic              srst,
  input  logic              en,
  input  logic [REQ_NB-1:0] req,
  output logic [REQ_NB-1:0] grant
);

  localparam int GW = $clog2(GRP_SZ);
  localparam int TW = $clog2(GRP_NB);

  logic [GRP_NB-1:0][GW-1:0] gptr_q;
  logic [GRP_NB-1:0][GW-1:0] gptr_d;
  logic [TW-1:0]             tptr_q;
  logic [TW-1:0]             tptr_d;
  logic [REQ_NB-1:0]         grant_q;
  logic [REQ_NB-1:0]         grant_d;

  logic [GRP_NB-1:0]         gv;
  logic [GRP_NB-1:0][GW-1:0] cand_all;
  logic [TW-1:0]             sel_grp;

  genvar gi;
  generate
    for (gi = 0; gi < GRP_NB; gi++) begin : g_grp
      logic [GRP_SZ-1:0] grp_req;
      logic [GW-1:0]     grp_cand;

      assign grp_req = req[gi*GRP_SZ +: GRP_SZ];

      // Circular search starting at this group's pointer; the GW-bit add wraps 7->0.
      always_comb begin : g_search
        logic [GW-1:0] idx;
        logic          found;
        found    = 1'b0;
        grp_cand = gptr_q[gi];
        idx      = '0;
        for (int k = 0; k < GRP_SZ; k++) begin
          idx = gptr_q[gi] + GW'(k);
          if (!found && grp_req[idx]) begin
            grp_cand = idx;
            found    = 1'b1;
          end
        end
      end

      assign gv[gi]       = |grp_req;
      assign cand_all[gi] = grp_cand;
    end
  endgenerate

  always_comb begin : top_search
    logic [TW-1:0] gidx;
    logic          found;
    found   = 1'b0;
    sel_grp = tptr_q;
    gidx    = '0;
    for (int k = 0; k < GRP_NB; k++) begin
      gidx = tptr_q + TW'(k);
      if (!found && gv[gidx]) begin
        sel_grp = gidx;
        found   = 1'b1;
      end
    end
  end

  // Pointers move only for the winning group; losers keep their rotation position.
  always_comb begin
    grant_d = '0;
    tptr_d  = tptr_q;
    gptr_d  = gptr_q;
    if (en && (|gv)) begin
      grant_d[{sel_grp, cand_all[sel_grp]}] = 1'b1;
      tptr_d                                = sel_grp + 1'b1;
      gptr_d[sel_grp]                       = cand_all[sel_grp] + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      grant_q <= '0;
      tptr_q  <= '0;
      gptr_q  <= '0;
    end else begin
      grant_q <= grant_d;
      tptr_q  <= tptr_d;
      gptr_q  <= gptr_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter_32.sv
// Directed and randomized bench for round_robin_arbiter_32.
module tb_round_robin_arbiter_32;

  logic        clk_i = 1'b0;
  logic        srst;
  logic        en;
  logic [31:0] req;
  logic [31:0] grant;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_tptr;
  int m_gptr [4];

  always #5 clk_i = ~clk_i;

  round_robin_arbiter_32 dut (
    .clk_i (clk_i),
    .srst  (srst),
    .en    (en),
    .req   (req),
    .grant (grant)
  );

  // Inputs are driven at negedge; one step passes a rising edge and returns to negedge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    $display("cyc %0d srst=%0b en=%0b req=%08h grant=%08h", cyc, srst, en, req, grant);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    en   = 1'b0;
    req  = '0;
    step();
    srst = 1'b0;
    en   = 1'b1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    en   = 1'b0;
    req  = 32'hFFFF_FFFF;
    step();
    total++;
    if (grant !== 32'h0) begin
      bad++;
      $display("FAIL reset_grant got=%08h exp=%08h", grant, 32'h0);
    end
    srst = 1'b0;
    en   = 1'b1;
    req  = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (grant !== 32'h0) begin
        bad++;
        $display("FAIL idle_grant cycle=%0d got=%08h exp=%08h", i, grant, 32'h0);
      end
    end
  endtask

  task automatic test_walking();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      exp = 32'h1 << i;
      req = exp;
      for (int k = 0; k < 2; k++) begin
        step();
        total++;
        if (grant !== exp) begin
          bad++;
          $display("FAIL walk_grant i=%0d k=%0d got=%08h exp=%08h", i, k, grant, exp);
        end
      end
    end
    req = '0;
    step();
    total++;
    if (grant !== 32'h0) begin
      bad++;
      $display("FAIL walk_drop got=%08h exp=%08h", grant, 32'h0);
    end
  endtask

  task automatic test_same_group();
    int          cnt3 = 0;
    int          cnt6 = 0;
    logic [31:0] exp;
    do_reset();
    req = (32'h1 << 3) | (32'h1 << 6);
    for (int c = 0; c < 64; c++) begin
      exp = (c % 2 == 0) ? (32'h1 << 3) : (32'h1 << 6);
      step();
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL pair_order c=%0d got=%08h exp=%08h", c, grant, exp);
      end
      if (grant[3]) cnt3++;
      if (grant[6]) cnt6++;
    end
    total++;
    if (cnt3 != 32 || cnt6 != 32) begin
      bad++;
      $display("FAIL pair_counts got=%0d/%0d exp=32/32", cnt3, cnt6);
    end
  endtask

  task automatic test_cross_group();
    int          cnt [4] = '{0, 0, 0, 0};
    int          bits [4] = '{2, 12, 20, 28};
    logic [31:0] exp;
    do_reset();
    req = '0;
    for (int b = 0; b < 4; b++) req[bits[b]] = 1'b1;
    for (int c = 0; c < 64; c++) begin
      exp = 32'h1 << bits[c % 4];
      step();
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL cross_order c=%0d got=%08h exp=%08h", c, grant, exp);
      end
      for (int b = 0; b < 4; b++) if (grant[bits[b]]) cnt[b]++;
    end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (cnt[b] != 16) begin
        bad++;
        $display("FAIL cross_count bit=%0d got=%0d exp=16", bits[b], cnt[b]);
      end
    end
  endtask

  task automatic test_all_requesting();
    int          cnt [32];
    int          last [32];
    int          max_wait = 0;
    int          idx;
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cnt[i]  = 0;
      last[i] = -1;
    end
    req = 32'hFFFF_FFFF;
    for (int c = 0; c < 96; c++) begin
      exp = 32'h1 << ((c % 4) * 8 + (c / 4) % 8);
      step();
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL all_order c=%0d got=%08h exp=%08h", c, grant, exp);
      end
      for (int i = 0; i < 32; i++) begin
        if (grant[i]) begin
          cnt[i]++;
          idx = (last[i] < 0) ? c + 1 : c - last[i];
          if (idx > max_wait) max_wait = idx;
          last[i] = c;
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (cnt[i] != 3) begin
        bad++;
        $display("FAIL all_count req=%0d got=%0d exp=3", i, cnt[i]);
      end
    end
    total++;
    if (max_wait > 32) begin
      bad++;
      $display("FAIL all_wait got=%0d exp<=32", max_wait);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    req = (32'h1 << 3) | (32'h1 << 6);
    step();
    total++;
    if (grant !== (32'h1 << 3)) begin
      bad++;
      $display("FAIL en_first got=%08h exp=%08h", grant, 32'h1 << 3);
    end
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (grant !== 32'h0) begin
        bad++;
        $display("FAIL en_low k=%0d got=%08h exp=%08h", k, grant, 32'h0);
      end
    end
    en = 1'b1;
    step();
    total++;
    if (grant !== (32'h1 << 6)) begin
      bad++;
      $display("FAIL en_resume got=%08h exp=%08h", grant, 32'h1 << 6);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    req = (32'h1 << 3) | (32'h1 << 6) | (32'h1 << 9);
    step();
    step();
    srst = 1'b1;
    step();
    total++;
    if (grant !== 32'h0) begin
      bad++;
      $display("FAIL midrst_grant got=%08h exp=%08h", grant, 32'h0);
    end
    srst = 1'b0;
    step();
    total++;
    if (grant !== (32'h1 << 3)) begin
      bad++;
      $display("FAIL midrst_restart got=%08h exp=%08h", grant, 32'h1 << 3);
    end
  endtask

  task automatic model_next(input logic [31:0] r, input logic e, input logic s,
                            output logic [31:0] g);
    bit done;
    int gg;
    int mm;
    g    = '0;
    done = 1'b0;
    if (s) begin
      m_tptr = 0;
      for (int i = 0; i < 4; i++) m_gptr[i] = 0;
    end else if (e) begin
      for (int gk = 0; gk < 4; gk++) begin
        gg = (m_tptr + gk) % 4;
        if (!done && r[gg*8 +: 8] != 8'h0) begin
          for (int mk = 0; mk < 8; mk++) begin
            mm = (m_gptr[gg] + mk) % 8;
            if (!done && r[gg*8 + mm]) begin
              g[gg*8 + mm] = 1'b1;
              m_gptr[gg]   = (mm + 1) % 8;
              m_tptr       = (gg + 1) % 4;
              done         = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] exp;
    logic [31:0] prev;
    do_reset();
    m_tptr = 0;
    for (int i = 0; i < 4; i++) m_gptr[i] = 0;
    for (int c = 0; c < 200; c++) begin
      for (int b = 0; b < 32; b++) r[b] = ($urandom_range(3) == 0);
      req  = r;
      en   = !(c >= 80 && c < 83);
      srst = (c == 140);
      prev = r;
      model_next(r, en, srst, exp);
      step();
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL rand_grant c=%0d got=%08h exp=%08h", c, grant, exp);
      end
      total++;
      if (!$onehot0(grant) || ((grant & ~prev) != 32'h0)) begin
        bad++;
        $display("FAIL rand_shape c=%0d got=%08h req=%08h", c, grant, prev);
      end
    end
    srst = 1'b0;
    en   = 1'b1;
    req  = '0;
  endtask

  initial begin
    srst = 1'b0;
    en   = 1'b0;
    req  = '0;
    @(negedge clk_i);
    test_reset();
    test_walking();
    test_same_group();
    test_cross_group();
    test_all_requesting();
    test_enable_hold();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_32.md
Name: round_robin_arbiter_32

Overview:
32-requester round-robin arbiter with registered one-hot grant. It is built hierarchically: four 8-way group arbiters (requesters 0-7, 8-15, 16-23, 24-31) feed one 4-way top-level arbiter that picks among groups. It is used wherever 32 sources share one resource and need fair, starvation-free access with glitch-free grant outputs.

Parameters:
REQ_NB, 32, number of requesters; fixed at 32 (4 groups x 8).
GRP_NB, 4, number of groups.
GRP_SZ, 8, requesters per group.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
srst  in  1  synchronous reset, active-high.
en  in  1  arbitration enable.
req  in  32  request vector; bit i = requester i wants access.
grant  out  32  registered grant, one-hot or all-zero.

Behaviour:
- Grant encoding:
  - grant is driven directly from a flop, with no combinational path from req to grant, so it changes only right after a clk_i rising edge.
  - grant is never multi-hot.
- Reset:
  - srst=1 at a rising edge sets grant=0.
  - All four group pointers are set to 0 and the top pointer to 0, so requester 0 / group 0 has highest priority.
  - Reset takes effect mid-operation too; a request pending at reset is re-arbitrated from the reset pointers.
- Latency: 1 cycle. req sampled at edge N is reflected in grant after edge N.
- Each cycle with en=1 and srst=0:
  - Group g computes gv[g] = OR of its 8 req bits and a candidate winner. The candidate is the first requesting index at or after gptr[g], searched with circular wrap 7->0.
  - The top arbiter picks the first group with gv=1 at or after tptr, with circular wrap 3->0.
  - grant <= one-hot of (selected group, its candidate). If req=0, grant <= 0.
- Pointer update, only when a grant is issued:
  - tptr <= (selected group + 1) mod 4.
  - gptr[selected] <= (candidate + 1) mod 8.
  - Non-selected groups keep their pointers, so a group's internal rotation advances only when that group actually wins.
- A single active requester is granted every cycle (work-conserving) while it stays asserted.
- en=0: grant <= 0 and all pointers hold. Re-enabling resumes from the held pointers.
- Fairness:
  - K continuously requesting inputs in the same group are served in strict rotation.
  - Continuously requesting inputs in different groups are served in group rotation.
  - Over any window of W cycles with constant req, per-requester grant counts among equally situated requesters differ by at most 1.
- Starvation bound: a continuously asserted request is granted within 32 cycles (worst case 4 groups x 8 members).
- Requests dropping: if req[i] deasserts, grant[i] deasserts at the next edge. No lock or hold semantics.

Test Plan:
1. Reset and enable: assert srst for 1 cycle, then en=1 with req=0 -> grant=0 in all cycles; no change on grant except within 200 ps after a clk_i edge.
2. Walking single request: for i=0..31, set req=1<<i and wait 2 edges -> grant=1<<i each time; grant=0 one cycle after req returns to 0.
3. Same-group pair: set req bits 3 and 6 for 64 cycles -> grant alternates 3,6,3,... with counts 32/32 (difference at most 1); grant is never multi-hot.
4. Cross-group four: set req bits 2, 12, 20, 28 for 64 cycles -> rotation 2,12,20,28 repeating, each count 16 +/- 1.
5. All 32 requesting for 96 cycles -> order 0,8,16,24,1,9,17,25,...; every requester granted exactly 3 times; no request waits more than 32 cycles.
6. Random traffic: 200 cycles, each bit set with 25% probability, changed at negedge -> grant one-hot or zero, and grant is a subset of the previous cycle's req. Also apply en=0 mid-traffic -> grant=0 next cycle with pointers held; apply srst mid-traffic -> grant=0 and pointers at 0.
